// File: rtl/lc3p_pkg.sv
// Shared definitions for the LC-3+ datapath: ALU opcodes, mux select encodings, memory FSM states
// and a sign-extension helper.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package lc3p_pkg;

  // Widest datapath the sign-extension helper supports; callers truncate to DATA_W.
  localparam int SEXT_W = 64;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOT  = 2'b11;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_ADDER = 2'b01,
    PC_BUS   = 2'b10,
    PC_HOLD  = 2'b11
  } sel_pc_e;

  typedef enum logic [1:0] {
    EAB2_ZERO  = 2'b00,
    EAB2_OFF6  = 2'b01,
    EAB2_OFF9  = 2'b10,
    EAB2_OFF11 = 2'b11
  } sel_eab2_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD_WAIT = 2'b01,
    ST_WR_WAIT = 2'b10
  } mem_state_e;

  // Treat bit 'msb' of value as the sign bit and replicate it into every higher bit.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] value, input int msb);
    logic [SEXT_W-1:0] hi_mask;
    logic              sign;
    hi_mask = {SEXT_W{1'b1}} << (msb + 1);
    sign    = |(value & (SEXT_W'(1) << msb));
    return sign ? (value | hi_mask) : (value & ~hi_mask);
  endfunction

endpackage

// File: rtl/lc3p_regfile.sv
// General-purpose register file: two combinational read ports, one synchronous write port.
// Latency: reads are combinational (pre-write value during a write cycle); writes land on the next edge.
// Backpressure: none, a write strobe is always accepted.
// Ports: clk/rst, ra_addr_i/rb_addr_i -> ra_o/rb_o, we_i + wa_i + wd_i write port.
module lc3p_regfile #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int RA_W      = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra_addr_i,
  input  logic [RA_W-1:0]   rb_addr_i,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] ra_o,
  output logic [DATA_W-1:0] rb_o
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_o = regs_q[ra_addr_i];
  assign rb_o = regs_q[rb_addr_i];

endmodule

// File: rtl/lc3p_datapath.sv
// LC-3+ datapath: PC/IR/MAR/MDR, NZP flags, register file, ALU, address adder, priority bus and
// a ready/valid memory FSM with timeout.
// Latency: register loads take effect on the next edge; a memory command at t raises mem_req at t+1,
//   and a mem_ready at t+1 updates MDR and clears mem_busy at t+2.
// Backpressure: mem_busy stalls the control unit; while busy, ldMAR/ldMDR are ignored and new
//   memory commands are rejected with a mem_err pulse. DATA_W is limited to 16..64.
// Ports: control strobes/selects from the control FSM, mem_* handshake to memory,
//   IR_OUT/N_OUT/Z_OUT/P_OUT back to the control FSM, bus_err flags multi-driver bus cycles.
module lc3p_datapath
  import lc3p_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                REG_COUNT   = 8,
  parameter int                RA_W        = $clog2(REG_COUNT),
  parameter logic [DATA_W-1:0] PC_RESET    = '0,
  parameter int                MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        aluControl,
  input  logic              enaALU,
  input  logic              enaPC,
  input  logic              enaMARM,
  input  logic              enaMDR,
  input  logic [RA_W-1:0]   SR1,
  input  logic [RA_W-1:0]   SR2,
  input  logic [RA_W-1:0]   DR,
  input  logic              regWE,
  input  logic              flagWE,
  input  logic              ldPC,
  input  logic              ldIR,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic [1:0]        selPC,
  input  logic              selMAR,
  input  logic              selEAB1,
  input  logic [1:0]        selEAB2,
  input  logic              memRd,
  input  logic              memWr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic              mem_err,
  output logic              bus_err,
  output logic [DATA_W-1:0] IR_OUT,
  output logic              N_OUT,
  output logic              Z_OUT,
  output logic              P_OUT
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [DATA_W-1:0] pc_q, pc_d, ir_q, mar_q, mdr_q;
  logic              n_q, z_q, p_q, bus_err_q, mem_err_q, mem_err_d, rd_done;
  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] ra, rb, sr2mux, alu, addr1, addr2, adder, marm, bus;

  lc3p_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .RA_W(RA_W)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_addr_i (SR1),
    .rb_addr_i (SR2),
    .we_i      (regWE),
    .wa_i      (DR),
    .wd_i      (bus),
    .ra_o      (ra),
    .rb_o      (rb)
  );

  // IR[5] picks the 5-bit immediate form of ADD/AND.
  assign sr2mux = ir_q[5] ? DATA_W'(sext(SEXT_W'(ir_q[4:0]), 4)) : rb;

  always_comb begin
    case (aluControl)
      ALU_ADD: alu = ra + sr2mux;
      ALU_AND: alu = ra & sr2mux;
      ALU_NOT: alu = ~ra;
      default: alu = ra;
    endcase
  end

  assign addr1 = selEAB1 ? ra : pc_q;

  always_comb begin
    case (sel_eab2_e'(selEAB2))
      EAB2_OFF6:  addr2 = DATA_W'(sext(SEXT_W'(ir_q[5:0]), 5));
      EAB2_OFF9:  addr2 = DATA_W'(sext(SEXT_W'(ir_q[8:0]), 8));
      EAB2_OFF11: addr2 = DATA_W'(sext(SEXT_W'(ir_q[10:0]), 10));
      default:    addr2 = '0;
    endcase
  end

  assign adder = addr1 + addr2;
  assign marm  = selMAR ? DATA_W'(ir_q[7:0]) : adder;

  // Fixed-priority bus: a conflicting lower-priority driver is simply shadowed and reported.
  always_comb begin
    if (enaALU)       bus = alu;
    else if (enaPC)   bus = pc_q;
    else if (enaMARM) bus = marm;
    else if (enaMDR)  bus = mdr_q;
    else              bus = '0;
  end

  always_comb begin
    pc_d = pc_q;
    if (ldPC) begin
      case (sel_pc_e'(selPC))
        PC_INC:   pc_d = pc_q + DATA_W'(1);
        PC_ADDER: pc_d = adder;
        PC_BUS:   pc_d = bus;
        default:  pc_d = pc_q;
      endcase
    end
  end

  // Memory FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory FSM: next state. The counter idles at zero so it is clear on entry to a wait state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (memRd && memWr) mem_err_d = 1'b1;
        else if (memRd)     state_d   = ST_RD_WAIT;
        else if (memWr)     state_d   = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (memRd || memWr) mem_err_d = 1'b1;
        if (mem_ready) begin
          state_d = ST_IDLE;
          rd_done = (state_q == ST_RD_WAIT);
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory FSM: outputs.
  always_comb begin
    mem_req  = (state_q != ST_IDLE);
    mem_we   = (state_q == ST_WR_WAIT);
    mem_busy = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b1;
      p_q       <= 1'b0;
      bus_err_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (ldIR) ir_q <= bus;
      if (ldMAR && !mem_busy) mar_q <= bus;
      if (rd_done)                 mdr_q <= mem_rdata;
      else if (ldMDR && !mem_busy) mdr_q <= bus;
      if (flagWE) begin
        n_q <= bus[DATA_W-1];
        z_q <= (bus == '0);
        p_q <= !bus[DATA_W-1] && (bus != '0);
      end
      bus_err_q <= ($countones({enaALU, enaPC, enaMARM, enaMDR}) > 1);
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign mem_err   = mem_err_q;
  assign bus_err   = bus_err_q;
  assign IR_OUT    = ir_q;
  assign N_OUT     = n_q;
  assign Z_OUT     = z_q;
  assign P_OUT     = p_q;

endmodule
